// File: rtl/object_pingpong_buffer_pkg.sv
// Shared types for the object ping-pong buffer: the object record handed from
// object generation to the rasterizer lanes, plus default sizing.
package object_pingpong_buffer_pkg;

  // One scene object as produced by object generation.
  typedef struct packed {
    logic [7:0]  id;
    logic [11:0] x;
    logic [11:0] y;
  } object_t;

  localparam int OBJ_DEPTH_DEFAULT    = 64;
  localparam int OBJ_NUM_READ_DEFAULT = 2;

  // Width of a count that must reach DEPTH itself, not just DEPTH-1.
  function automatic int obj_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Count/cursor type for the default bank depth.
  typedef logic [$clog2(OBJ_DEPTH_DEFAULT + 1)-1:0] obj_cnt_t;

endpackage

// File: rtl/object_pingpong_buffer_if.sv
// Bus between the frame producer/readers and the ping-pong object buffer.
//
// Handshake semantics: a write transfers on a rising clock edge where
// wr_valid && wr_ready. wr_valid may be asserted regardless of wr_ready;
// a write presented while wr_ready=0 is dropped and flagged by overflow.
// Each read port consumes the object shown on rd_data[i] at an edge where
// rd_en[i] && rd_valid[i]; rd_en while rd_end is high is a no-op. next_frame
// is a single-cycle pulse and takes precedence over reads in its cycle.
interface object_pingpong_buffer_if
  import object_pingpong_buffer_pkg::*;
#(
  parameter int DEPTH    = OBJ_DEPTH_DEFAULT,
  parameter int NUM_READ = OBJ_NUM_READ_DEFAULT
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                         next_frame;
  object_t                      wr_data;
  logic                         wr_valid;
  logic                         wr_ready;
  logic    [NUM_READ-1:0]       rd_en;
  object_t [NUM_READ-1:0]       rd_data;
  logic    [NUM_READ-1:0]       rd_valid;
  logic    [NUM_READ-1:0]       rd_end;
  logic    [CW-1:0]             front_count;
  logic    [CW-1:0]             back_count;
  logic                         full;
  logic                         overflow;

  // Producer / reader side.
  modport master (
    output next_frame, wr_data, wr_valid, rd_en,
    input  wr_ready, rd_data, rd_valid, rd_end,
    input  front_count, back_count, full, overflow
  );

  // Buffer side.
  modport slave (
    input  next_frame, wr_data, wr_valid, rd_en,
    output wr_ready, rd_data, rd_valid, rd_end,
    output front_count, back_count, full, overflow
  );

endinterface

// File: rtl/object_read_cursor.sv
// One independent read cursor over the front bank. Advances on a consumed
// read, saturates at front_count, and returns to zero on a frame swap.
module object_read_cursor #(
  parameter int CW = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          rd_en,
  input  logic [CW-1:0] front_count,
  output logic [CW-1:0] cursor,
  output logic          rd_valid,
  output logic          rd_end
);

  // Cursor register: clear wins over rd_en, so reads in a swap cycle are lost.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cursor <= '0;
    end else if (rd_en && rd_valid) begin
      cursor <= cursor + CW'(1);
    end
  end

  assign rd_valid = (cursor < front_count);
  assign rd_end   = (cursor == front_count);

endmodule

// File: rtl/object_pingpong_buffer.sv
// Double-buffered object store. The writer appends to the back bank while
// NUM_READ cursors walk the front bank; next_frame swaps the banks in one edge
// so readers only ever see complete frames.
module object_pingpong_buffer
  import object_pingpong_buffer_pkg::*;
#(
  parameter int DEPTH    = OBJ_DEPTH_DEFAULT,
  parameter int NUM_READ = OBJ_NUM_READ_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  object_pingpong_buffer_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          bank_sel;     // bank currently exposed to readers
  logic [CW-1:0] front_count;
  logic [CW-1:0] back_count;
  logic          overflow;
  logic          full;
  logic          wr_fire;

  object_t       mem [2][DEPTH];
  logic [CW-1:0] cursor [NUM_READ];

  assign full    = (back_count == CW'(DEPTH));
  assign wr_fire = bus.wr_valid && !full;

  // Bank select, counts and the sticky overflow flag; a swap resets the back side.
  always_ff @(posedge clock) begin
    if (reset) begin
      bank_sel    <= 1'b0;
      front_count <= '0;
      back_count  <= '0;
      overflow    <= 1'b0;
    end else if (bus.next_frame) begin
      bank_sel    <= ~bank_sel;
      // A write accepted in the swap cycle lands in the bank that becomes front.
      front_count <= back_count + CW'(wr_fire);
      back_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr_fire) begin
        back_count <= back_count + CW'(1);
      end
      if (bus.wr_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage write into the back bank; contents are never cleared.
  always_ff @(posedge clock) begin
    if (!reset && wr_fire) begin
      mem[~bank_sel][back_count[AW-1:0]] <= bus.wr_data;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    object_read_cursor #(.CW(CW)) u_cursor (
      .clock       (clock),
      .reset       (reset),
      .clear       (bus.next_frame),
      .rd_en       (bus.rd_en[i]),
      .front_count (front_count),
      .cursor      (cursor[i]),
      .rd_valid    (bus.rd_valid[i]),
      .rd_end      (bus.rd_end[i])
    );

    // Asynchronous read of the front bank; a parked-at-DEPTH cursor shows zero.
    assign bus.rd_data[i] = (cursor[i] < CW'(DEPTH)) ? mem[bank_sel][cursor[i][AW-1:0]] : '0;
  end

  assign bus.wr_ready    = !full;
  assign bus.full        = full;
  assign bus.overflow    = overflow;
  assign bus.front_count = front_count;
  assign bus.back_count  = back_count;

endmodule

// File: tb/tb_object_pingpong_buffer.sv
// Self-checking bench for object_pingpong_buffer (DEPTH=4, two read ports).
module tb_object_pingpong_buffer;
  import object_pingpong_buffer_pkg::*;

  localparam int DEPTH    = 4;
  localparam int NUM_READ = 2;
  localparam int OW       = $bits(object_t);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  object_pingpong_buffer_if #(.DEPTH(DEPTH), .NUM_READ(NUM_READ)) bus ();

  object_pingpong_buffer #(.DEPTH(DEPTH), .NUM_READ(NUM_READ)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard / model ----------------
  int error_count = 0;
  int check_count = 0;

  logic [OW-1:0] back_q[$];   // objects accepted into the back bank this frame
  logic [OW-1:0] exp_q0[$];   // remaining objects port 0 must deliver
  logic [OW-1:0] exp_q1[$];   // remaining objects port 1 must deliver
  int m_front_count = 0;
  logic m_overflow = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every visible output against the model state.
  task automatic check_outputs();
    int bc;
    bc = back_q.size();
    check_val("front_count", 32'(bus.front_count), 32'(m_front_count));
    check_val("back_count",  32'(bus.back_count),  32'(bc));
    check_val("full",        32'(bus.full),        32'(bc == DEPTH));
    check_val("wr_ready",    32'(bus.wr_ready),    32'(bc != DEPTH));
    check_val("overflow",    32'(bus.overflow),    32'(m_overflow));
    check_val("rd_valid",    32'(bus.rd_valid),    {30'd0, exp_q1.size() != 0, exp_q0.size() != 0});
    check_val("rd_end",      32'(bus.rd_end),      {30'd0, exp_q1.size() == 0, exp_q0.size() == 0});
    if (exp_q0.size() != 0) check_val("rd0_head", 32'(bus.rd_data[0]), 32'(exp_q0[0]));
    if (exp_q1.size() != 0) check_val("rd1_head", 32'(bus.rd_data[1]), 32'(exp_q1[0]));
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of stimulus, advance the model at the edge, then check.
  task automatic step(input logic wv, input object_t wd, input logic nf, input logic [1:0] re);
    logic wfire;
    bus.wr_valid   = wv;
    bus.wr_data    = wd;
    bus.next_frame = nf;
    bus.rd_en      = re;
    wfire = wv && (back_q.size() < DEPTH);
    // Data consumed this cycle must match the scoreboard head.
    if (!nf && re[0] && exp_q0.size() != 0) check_val("rd0_consume", 32'(bus.rd_data[0]), 32'(exp_q0[0]));
    if (!nf && re[1] && exp_q1.size() != 0) check_val("rd1_consume", 32'(bus.rd_data[1]), 32'(exp_q1[0]));
    @(posedge clock);
    #1;
    if (nf) begin
      if (wfire) back_q.push_back(wd);
      exp_q0 = back_q;
      exp_q1 = back_q;
      m_front_count = back_q.size();
      back_q.delete();
      m_overflow = 1'b0;
    end else begin
      if (wfire) back_q.push_back(wd);
      else if (wv) m_overflow = 1'b1;
      if (re[0] && exp_q0.size() != 0) void'(exp_q0.pop_front());
      if (re[1] && exp_q1.size() != 0) void'(exp_q1.pop_front());
    end
    bus.wr_valid   = 1'b0;
    bus.next_frame = 1'b0;
    bus.rd_en      = '0;
    check_outputs();
  endtask

  // Reset with every other input active, to show reset takes priority.
  task automatic do_reset();
    reset          = 1'b1;
    bus.wr_valid   = 1'b1;
    bus.wr_data    = object_t'(32'hdead_beef);
    bus.next_frame = 1'b1;
    bus.rd_en      = '1;
    @(posedge clock);
    #1;
    reset          = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.next_frame = 1'b0;
    bus.rd_en      = '0;
    back_q.delete();
    exp_q0.delete();
    exp_q1.delete();
    m_front_count = 0;
    m_overflow    = 1'b0;
    check_outputs();
    check_val("reset_rd_end", 32'(bus.rd_end), 32'd3);
  endtask

  function automatic object_t obj(input logic [7:0] id);
    object_t o;
    o.id = id;
    o.x  = 12'(id) * 12'd3 + 12'd17;
    o.y  = 12'(id) * 12'd5 + 12'd101;
    return o;
  endfunction

  object_t none;

  // ---------------- stimulus ----------------
  initial begin
    none = '0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.next_frame = 1'b0;
    bus.rd_en      = '0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Three writes A,B,C then swap.
    step(1'b1, obj(8'hA1), 1'b0, 2'b00);
    step(1'b1, obj(8'hB2), 1'b0, 2'b00);
    step(1'b1, obj(8'hC3), 1'b0, 2'b00);
    step(1'b0, none, 1'b1, 2'b00);
    check_val("t1_front_count", 32'(bus.front_count), 32'd3);
    check_val("t1_rd0_is_A", 32'(bus.rd_data[0]), 32'(obj(8'hA1)));
    check_val("t1_rd_valid", 32'(bus.rd_valid), 32'd3);

    // Port 0 walks to the end; port 1 stays put; extra rd_en saturates.
    repeat (3) step(1'b0, none, 1'b0, 2'b01);
    check_val("t2_rd0_end", 32'(bus.rd_end[0]), 32'd1);
    check_val("t2_rd1_is_A", 32'(bus.rd_data[1]), 32'(obj(8'hA1)));
    step(1'b0, none, 1'b0, 2'b01);
    check_val("t2_rd0_saturated", 32'(bus.rd_end[0]), 32'd1);

    // Fill to DEPTH, then one more write overflows; swap clears overflow.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, obj(8'(8'h10 + i)), 1'b0, 2'b00);
      if (i == 3) check_val("t3_full_after_4", 32'({bus.full, bus.wr_ready}), 32'b10);
    end
    check_val("t3_overflow", 32'(bus.overflow), 32'd1);
    step(1'b0, none, 1'b1, 2'b00);
    check_val("t3_front_count", 32'(bus.front_count), 32'd4);
    check_val("t3_overflow_clr", 32'(bus.overflow), 32'd0);

    // Write in the swap cycle joins the new front.
    step(1'b1, obj(8'h21), 1'b0, 2'b00);
    step(1'b1, obj(8'h22), 1'b0, 2'b00);
    step(1'b1, obj(8'hD4), 1'b1, 2'b11);
    check_val("t4_front_count", 32'(bus.front_count), 32'd3);
    check_val("t4_back_empty", 32'(bus.back_count), 32'd0);
    step(1'b0, none, 1'b0, 2'b01);
    step(1'b0, none, 1'b0, 2'b01);
    check_val("t4_D_at_2", 32'(bus.rd_data[0]), 32'(obj(8'hD4)));

    // Write next frame during traversal; readers unaffected until swap.
    step(1'b1, obj(8'hE5), 1'b0, 2'b10);
    step(1'b1, obj(8'hF6), 1'b0, 2'b01);
    step(1'b0, none, 1'b1, 2'b00);
    check_val("t5_E_at_0", 32'(bus.rd_data[1]), 32'(obj(8'hE5)));
    step(1'b0, none, 1'b0, 2'b10);
    check_val("t5_F_at_1", 32'(bus.rd_data[1]), 32'(obj(8'hF6)));

    // Empty frame and back-to-back swaps.
    step(1'b0, none, 1'b1, 2'b00);
    check_val("empty_rd_end", 32'(bus.rd_end), 32'd3);
    step(1'b1, obj(8'h31), 1'b1, 2'b00);
    step(1'b0, none, 1'b1, 2'b00);

    // Reset mid-traversal with write/swap/reads all asserted.
    step(1'b1, obj(8'h41), 1'b0, 2'b00);
    step(1'b0, none, 1'b1, 2'b00);
    step(1'b1, obj(8'h42), 1'b0, 2'b00);
    do_reset();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), object_t'($urandom),
           1'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
